// File: rtl/regfile_pkg.sv
// Shared defaults for the bypassing register file and its busy scoreboard.
package regfile_pkg;
    localparam int REGFILE_DATA_W   = 32;
    localparam int REGFILE_NUM_REGS = 32;
    localparam int REGFILE_NUM_READ = 2;
    // Index of the hard-wired zero register when ZERO_REG is enabled.
    localparam int REG_ZERO         = 0;
endpackage

// File: rtl/regfile_bypass_if.sv
// Operand-fetch, writeback and issue signals of the ID-stage register file.
interface regfile_bypass_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = REGFILE_DATA_W,
    parameter int NUM_REGS = REGFILE_NUM_REGS,
    parameter int NUM_READ = REGFILE_NUM_READ
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [NUM_READ*ADDR_W-1:0] rd_addr;
    logic [NUM_READ*DATA_W-1:0] rd_data;
    logic [NUM_READ-1:0]        rd_busy;
    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic                       issue_en;
    logic [ADDR_W-1:0]          issue_addr;
    logic                       any_busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
        input  rd_data, rd_busy, any_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
        output rd_data, rd_busy, any_busy
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, set wins a tie.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int  NUM_REGS = REGFILE_NUM_REGS,
    parameter int  ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_addr,
    output logic [NUM_REGS-1:0] busy,
    output logic                any_busy
);
    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
            // The zero register never has a pending producer.
            localparam bit IS_ZERO = (ZERO_REG != 0) && (gi == REG_ZERO);
            assign set_vec[gi] = !IS_ZERO && issue_en && (issue_addr == ADDR_W'(gi));
            assign clr_vec[gi] = wr_en && (wr_addr == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= (busy_reg & ~clr_vec) | set_vec;
        end
    end

    assign busy     = busy_reg;
    assign any_busy = !reset && (|busy_reg);
endmodule

// File: rtl/regfile_bypass.sv
// ID-stage register file: async read ports with same-cycle writeback bypass.
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int  DATA_W   = REGFILE_DATA_W,
    parameter int  NUM_REGS = REGFILE_NUM_REGS,
    parameter int  NUM_READ = REGFILE_NUM_READ,
    parameter int  ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            reset,
    regfile_bypass_if.slave rf
);
    logic [DATA_W-1:0]   regs_reg [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                sb_any_busy;
    logic                wr_drop;

    assign wr_drop = (ZERO_REG != 0) && (rf.wr_addr == ADDR_W'(REG_ZERO));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (rf.wr_en && !wr_drop) begin
            regs_reg[rf.wr_addr] <= rf.wr_data;
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (rf.wr_en),
        .wr_addr    (rf.wr_addr),
        .issue_en   (rf.issue_en),
        .issue_addr (rf.issue_addr),
        .busy       (busy),
        .any_busy   (sb_any_busy)
    );

    assign rf.any_busy = sb_any_busy;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic              is_zero;
            logic              hit;

            assign addr    = rf.rd_addr[gi*ADDR_W +: ADDR_W];
            assign is_zero = (ZERO_REG != 0) && (addr == ADDR_W'(REG_ZERO));
            // A writeback to the same register this cycle satisfies the read.
            assign hit     = rf.wr_en && (rf.wr_addr == addr);

            assign rf.rd_data[gi*DATA_W +: DATA_W] =
                (reset || is_zero) ? '0 :
                hit                ? rf.wr_data :
                                     regs_reg[addr];
            assign rf.rd_busy[gi] = !reset && busy[addr] && !hit;
        end
    endgenerate
endmodule
